// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - RV32M DIV/DIVU/REM/REMU sequencer driving a shared ALU (optional DIV_SEQ_STATS_EN adds op_count)
module div_sequencer #(
  parameter int         XLEN       = 32,
  parameter logic [3:0] ALU_OP_ADD = 4'b0000,
  parameter logic [3:0] ALU_OP_SUB = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      funct,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [XLEN-1:0] alu_operand_a,
  output logic [XLEN-1:0] alu_operand_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result
`ifdef DIV_SEQ_STATS_EN
  ,
  output logic [31:0]     op_count
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NEG_A = 3'd1;
  localparam logic [2:0] S_NEG_B = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FIX   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state_q, state_d;
  logic [1:0]      funct_q, funct_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] mag_q, mag_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     op_count_q, op_count_d;

  logic            signed_op, rem_op, accept;
  logic [XLEN-1:0] shifted, fix_src;
  logic            hi, borrow, qbit, fix_neg;

  assign signed_op    = ~funct_q[0];
  assign rem_op       = funct_q[1];
  assign accept       = start_valid && (state_q == S_IDLE) && !flush;
  assign start_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = rvalid_q;
  assign result       = result_q;
`ifdef DIV_SEQ_STATS_EN
  assign op_count     = op_count_q;
`endif

  // Next-state logic and ALU request for each step of the division
  always_comb begin
    state_d       = state_q;
    funct_d       = funct_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    mag_d         = mag_q;
    cnt_d         = cnt_q;
    special_d     = special_q;
    result_d      = result_q;
    rvalid_d      = rvalid_q;
    op_count_d    = op_count_q;
    alu_operand_a = '0;
    alu_operand_b = '0;
    alu_op        = ALU_OP_ADD;
    shifted       = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    hi            = rem_q[XLEN-1];
    borrow        = 1'b0;
    qbit          = 1'b0;
    fix_src       = rem_op ? rem_q : quo_q;
    fix_neg       = !special_q && signed_op &&
                    (rem_op ? dvd_q[XLEN-1] : (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]));

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct_d   = funct;
          dvd_d     = dividend;
          dvs_d     = divisor;
          special_d = 1'b0;
          state_d   = S_NEG_A;
          // Special cases preload the final answer and skip straight to FIX,
          // where special_q suppresses any sign correction.
          if (divisor == '0) begin
            quo_d     = '1;
            rem_d     = dividend;
            special_d = 1'b1;
            state_d   = S_FIX;
          end else if (!funct[0] && dividend == INT_MIN && divisor == '1) begin
            quo_d     = INT_MIN;
            rem_d     = '0;
            special_d = 1'b1;
            state_d   = S_FIX;
          end
        end
      end
      S_NEG_A: begin
        alu_operand_b = dvd_q;
        alu_op        = ALU_OP_SUB;
        quo_d         = (signed_op && dvd_q[XLEN-1]) ? alu_result : dvd_q;
        rem_d         = '0;
        state_d       = S_NEG_B;
      end
      S_NEG_B: begin
        alu_operand_b = dvs_q;
        alu_op        = ALU_OP_SUB;
        mag_d         = (signed_op && dvs_q[XLEN-1]) ? alu_result : dvs_q;
        cnt_d         = 5'd31;
        state_d       = S_ITER;
      end
      S_ITER: begin
        alu_operand_a = shifted;
        alu_operand_b = mag_q;
        alu_op        = ALU_OP_SUB;
        // Unsigned borrow of shifted - mag recovered from the ALU sign bit;
        // a set hi bit means the 33-bit partial remainder always exceeds mag.
        borrow  = (~shifted[XLEN-1] & mag_q[XLEN-1]) |
                  (~(shifted[XLEN-1] ^ mag_q[XLEN-1]) & alu_result[XLEN-1]);
        qbit    = hi | ~borrow;
        rem_d   = qbit ? alu_result : shifted;
        quo_d   = {quo_q[XLEN-2:0], qbit};
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIX;
      end
      S_FIX: begin
        alu_operand_b = fix_src;
        alu_op        = ALU_OP_SUB;
        result_d      = fix_neg ? alu_result : fix_src;
        rvalid_d      = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        if (result_ready) begin
          rvalid_d   = 1'b0;
          state_d    = S_IDLE;
          op_count_d = op_count_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the op without delivering or counting a result.
    if (flush) begin
      state_d    = S_IDLE;
      rvalid_d   = 1'b0;
      op_count_d = op_count_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      funct_q    <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
      result_q   <= '0;
      rvalid_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      funct_q    <= funct_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      special_q  <= special_d;
      result_q   <= result_d;
      rvalid_q   <= rvalid_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  funct;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
`ifdef DIV_SEQ_STATS_EN
  logic [31:0] op_count;
  logic [31:0] cnt_before;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference shared ALU: ADD/SUB only.
  assign alu_result = (alu_op == 4'b0001) ? (alu_operand_a - alu_operand_b)
                                          : (alu_operand_a + alu_operand_b);

  div_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .funct         (funct),
    .dividend      (dividend),
    .divisor       (divisor),
    .flush         (flush),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result        (result),
    .busy          (busy),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result)
`ifdef DIV_SEQ_STATS_EN
    ,
    .op_count      (op_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_eq("start_ready_idle", {31'd0, start_ready}, 32'd1);
    funct       = f;
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    start_valid = 1'b0;
    while (!result_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    issue(f, a, b);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, result, exp);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check_eq({tag, "_drop"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst          = 1'b1;
    start_valid  = 1'b0;
    funct        = 2'b00;
    dividend     = '0;
    divisor      = '0;
    flush        = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, start_ready}, 32'd1);
    check_eq("rst_alu_a", alu_operand_a, 32'd0);
    check_eq("rst_alu_b", alu_operand_b, 32'd0);
    check_eq("rst_alu_op", {28'd0, alu_op}, 32'd0);
`ifdef DIV_SEQ_STATS_EN
    check_eq("rst_op_count", op_count, 32'd0);
`endif

    run_op(2'b01, 32'd100, 32'd7, 32'd14, 35, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 35, "remu_100_7");
    run_op(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, "div_m7_2");
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, "rem_m7_2");
    run_op(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 35, "div_7_m2");
    run_op(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 35, "divu_max_1");
    run_op(2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 35, "remu_max_min");
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_5_0");
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");

    // Backpressure in DONE.
    issue(2'b01, 32'd100, 32'd7);
    wait_valid(lat);
    check_eq("bp_lat", 32'(lat), 32'd35);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_valid", {31'd0, result_valid}, 32'd1);
      check_eq("bp_result", result, 32'd14);
      check_eq("bp_start_ready", {31'd0, start_ready}, 32'd0);
      check_eq("bp_busy", {31'd0, busy}, 32'd1);
      check_eq("bp_alu_op", {28'd0, alu_op}, 32'd0);
      check_eq("bp_alu_a", alu_operand_a, 32'd0);
      check_eq("bp_alu_b", alu_operand_b, 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check_eq("bp_drop", {31'd0, result_valid}, 32'd0);

    // Flush on the 10th ITER cycle.
`ifdef DIV_SEQ_STATS_EN
    cnt_before = op_count;
`endif
    issue(2'b01, 32'd100, 32'd7);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    check_eq("flush_valid", {31'd0, result_valid}, 32'd0);
    check_eq("flush_ready", {31'd0, start_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (result_valid) seen++;
    end
    check_eq("flush_no_result", 32'(seen), 32'd0);
`ifdef DIV_SEQ_STATS_EN
    check_eq("flush_not_counted", op_count, cnt_before);
`endif
    run_op(2'b01, 32'd9, 32'd3, 32'd3, 35, "divu_9_3");
`ifdef DIV_SEQ_STATS_EN
    check_eq("count_after_9_3", op_count, cnt_before + 32'd1);
`endif

    // Flush coincident with start_valid blocks the accept.
    @(negedge clk);
    funct       = 2'b01;
    dividend    = 32'd50;
    divisor     = 32'd5;
    start_valid = 1'b1;
    flush       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    flush       = 1'b0;
    check_eq("flush_blocks_accept", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
